aes_round_key_gen: RTL and testbench
====================================

// Module: aes_round_key_gen
//
// PURPOSE
//  On-demand AES-128 key expansion stage, directly upstream of the encryption core.
//  Latches the 4x4 cipher key, then returns one round key (rounds 1..10) per
//  request over the core's key_req/key_vld handshake.
//  Round 0 (the cipher key itself) is not issued: the core applies it in the initial AddRoundKey.
//  Uses an internal 4-byte S-box lookup (SubWord); no shared S-box arbitration.
//
// PARAMETERS
//  NO_ROWS    4   state/key matrix rows (fixed at 4 for AES)
//  NO_COLS    4   state/key matrix columns (Nk=4, AES-128 only)
//  NO_ROUNDS  10  round keys issued after a load
//
// PORTS
//  aes_clk       in   1                 clock, all state on rising edge
//  resetn        in   1                 asynchronous, active-low reset
//  key_gen_en    in   1                 block enable; low forces IDLE
//  key_load_i    in   1                 1-cycle strobe: latch cipher_key_i, restart expansion
//  cipher_key_i  in   [7:0][ROWS][COLS] cipher key, byte k[4c+r] at [r][c]
//  key_req_i     in   1                 request next round key (from core key_req_o)
//  key_vld_o     out  1                 1-cycle pulse: round_key_o/round_idx_o valid
//  round_key_o   out  [7:0][ROWS][COLS] current round key, same layout as cipher_key_i
//  round_idx_o   out  4                 index of round_key_o (0 after load, 1..10 issued)
//  key_done_o    out  1                 high once round 10 issued, until reload/disable
//
// BEHAVIOUR
//  Reset: state=IDLE; key_vld_o=0, key_done_o=0, round_idx_o=0, round_key_o all 0x00, rcon=0x01.
//  Column word w[c] = {m[0][c],m[1][c],m[2][c],m[3][c]}. Expansion from the previous key:
//   t = SubWord(RotWord(w[3])) ^ {rcon,00,00,00}
//   n[0] = w[0]^t
//   n[c] = n[c-1]^w[c] for c=1..3
//  rcon sequence: 01,02,04,08,10,20,40,80,1b,36; update is xtime (<<1, ^0x1b on carry), 8-bit.
//  FSM states: IDLE, READY, CALC, VALID, DONE.
//   IDLE : key_gen_en && key_load_i -> READY; round_key_o=cipher_key_i, round_idx_o=0, rcon=01.
//   READY: key_req_i=1 -> CALC (request accepted at this edge N).
//   CALC : at edge N+1, round_key_o=next key, round_idx_o+=1, key_vld_o=1, rcon advances -> VALID.
//   VALID: key_vld_o=0; next state is DONE if round_idx_o==NO_ROUNDS, else READY.
//   DONE : key_done_o=1; key_req_i ignored (no key_vld_o); holds last key.
//  Latency: accepted request -> key_vld_o high exactly 1 cycle later, for exactly 1 cycle.
//  key_req_i held high: a new key every 3 cycles (READY->CALC->VALID); level, not edge, sensitive.
//  key_req_i in IDLE/CALC/VALID/DONE: ignored, not queued.
//  round_key_o and round_idx_o are stable between pulses; they change only on load or at CALC.
//  key_load_i in any state (enabled): wins over key_req_i at the same edge.
//   Effects: aborts any CALC in progress, key_vld_o=0, key_done_o=0, -> READY with the new key.
//  key_gen_en=0 (sync): -> IDLE; key_vld_o=0, key_done_o=0, round_idx_o=0; round_key_o retained.
//  resetn low mid-expansion: immediate return to the reset values; no partial key is ever flagged.
//
// TESTING
//  1 Reset mid-CALC: assert resetn=0 -> all outputs reset asynchronously; the next load works normally.
//  2 FIPS-197 A.1 vector: load key 2b7e151628aed2a6abf7158809cf4f3c, 1 request.
//    -> 1 cycle later key_vld_o pulse, round_idx_o=1, key a0fafe1788542cb123a339392a6c7605.
//  3 Same key, 10 requests -> round 10 key d014f9a8c9ee2589e13f0cc8b6630ca6.
//    Then key_done_o=1; an 11th request produces no pulse.
//  4 key_req_i held high after load -> pulses exactly 3 cycles apart, idx 1..10, then none.
//  5 key_load_i and key_req_i in the same cycle as a CALC -> no pulse.
//    Following request yields round 1 of the new key; rcon is back to 01.
//  6 key_gen_en dropped after round 4 -> IDLE, idx=0, done=0; requests ignored until a new load.

Source files
------------

// File: rtl/aes_round_key_gen.sv
// On-demand AES-128 key expansion: latches a cipher key, then issues round keys 1..10,
// one per accepted request, over the encryption core's key_req/key_vld handshake.
module aes_round_key_gen #(
   parameter int unsigned NO_ROWS   = 4,
   parameter int unsigned NO_COLS   = 4,
   parameter int unsigned NO_ROUNDS = 10
) (
   input  logic                                 aes_clk,
   input  logic                                 resetn,
   input  logic                                 key_gen_en,
   input  logic                                 key_load_i,
   input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] cipher_key_i,
   input  logic                                 key_req_i,
   output logic                                 key_vld_o,
   output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] round_key_o,
   output logic [3:0]                           round_idx_o,
   output logic                                 key_done_o
);

   localparam int unsigned IDX_W  = 4;
   localparam int unsigned WORD_W = 8 * NO_ROWS;
   localparam logic [7:0]  RCON_INIT = 8'h01;

   typedef logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] key_mat_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READY = 3'd1,
      CALC  = 3'd2,
      VALID = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   state_t              r_state, w_state_nxt;
   key_mat_t            r_key,   w_key_nxt;
   logic [IDX_W-1:0]    r_idx,   w_idx_nxt;
   logic [7:0]          r_rcon,  w_rcon_nxt;
   logic                r_vld,   w_vld_nxt;
   logic                r_done,  w_done_nxt;

   logic [NO_COLS-1:0][WORD_W-1:0] w_col;
   logic [NO_COLS-1:0][WORD_W-1:0] w_new;
   logic [WORD_W-1:0]              w_rot;
   logic [WORD_W-1:0]              w_t;
   key_mat_t                       w_next_key;

   // Next round key from the current one: column words, RotWord/SubWord/rcon, xor chain
   always_comb begin
      w_col      = '0;
      w_new      = '0;
      w_rot      = '0;
      w_t        = '0;
      w_next_key = '0;
      for (int c = 0; c < NO_COLS; c++) begin
         for (int r = 0; r < NO_ROWS; r++) begin
            w_col[c][WORD_W-1-8*r -: 8] = r_key[r][c];
         end
      end
      w_rot = {w_col[NO_COLS-1][WORD_W-9:0], w_col[NO_COLS-1][WORD_W-1 -: 8]};
      for (int r = 0; r < NO_ROWS; r++) begin
         w_t[WORD_W-1-8*r -: 8] = SBOX[w_rot[WORD_W-1-8*r -: 8]];
      end
      w_t[WORD_W-1 -: 8] = w_t[WORD_W-1 -: 8] ^ r_rcon;
      w_new[0] = w_col[0] ^ w_t;
      for (int c = 1; c < NO_COLS; c++) begin
         w_new[c] = w_new[c-1] ^ w_col[c];
      end
      for (int c = 0; c < NO_COLS; c++) begin
         for (int r = 0; r < NO_ROWS; r++) begin
            w_next_key[r][c] = w_new[c][WORD_W-1-8*r -: 8];
         end
      end
   end

   // Next-state and registered-output logic; disable beats load, load beats request
   always_comb begin
      w_state_nxt = r_state;
      w_key_nxt   = r_key;
      w_idx_nxt   = r_idx;
      w_rcon_nxt  = r_rcon;
      w_vld_nxt   = 1'b0;
      w_done_nxt  = r_done;
      if (!key_gen_en) begin
         w_state_nxt = IDLE;
         w_idx_nxt   = '0;
         w_done_nxt  = 1'b0;
      end else if (key_load_i) begin
         w_state_nxt = READY;
         w_key_nxt   = cipher_key_i;
         w_idx_nxt   = '0;
         w_rcon_nxt  = RCON_INIT;
         w_done_nxt  = 1'b0;
      end else begin
         case (r_state)
            IDLE:  w_state_nxt = IDLE;
            READY: begin
               if (key_req_i) w_state_nxt = CALC;
            end
            CALC: begin
               w_state_nxt = VALID;
               w_key_nxt   = w_next_key;
               w_idx_nxt   = r_idx + IDX_W'(1);
               w_vld_nxt   = 1'b1;
               w_rcon_nxt  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
            end
            VALID: begin
               if (r_idx == IDX_W'(NO_ROUNDS)) begin
                  w_state_nxt = DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = READY;
               end
            end
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge aes_clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_key   <= '0;
         r_idx   <= '0;
         r_rcon  <= RCON_INIT;
         r_vld   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_key   <= w_key_nxt;
         r_idx   <= w_idx_nxt;
         r_rcon  <= w_rcon_nxt;
         r_vld   <= w_vld_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign key_vld_o   = r_vld;
   assign round_key_o = r_key;
   assign round_idx_o = r_idx;
   assign key_done_o  = r_done;

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Self-checking bench for aes_round_key_gen: transaction-level AES-128 expansion model
// (S-box derived from GF(2^8) inversion) compared against the DUT every cycle.
module tb_aes_round_key_gen;

   typedef logic [3:0][3:0][7:0] mat_t;
   typedef mat_t rk_arr_t [11];

   localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       load;
   logic       req;
   mat_t       key;
   logic       key_vld_o;
   mat_t       round_key_o;
   logic [3:0] round_idx_o;
   logic       key_done_o;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   logic [7:0] SB [256];

   // model state
   mat_t    m_key;
   rk_arr_t m_rk;
   int      m_idx;
   bit      m_vld, m_done, m_active, m_pend, m_wait;

   aes_round_key_gen dut (
      .aes_clk      (clk),
      .resetn       (rst_n),
      .key_gen_en   (en),
      .key_load_i   (load),
      .cipher_key_i (key),
      .key_req_i    (req),
      .key_vld_o    (key_vld_o),
      .round_key_o  (round_key_o),
      .round_idx_o  (round_idx_o),
      .key_done_o   (key_done_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(a, 8'(y)) == 8'h01) inv = 8'(y);
      return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
   endfunction

   // byte i of the hex string sits at row i%4, column i/4
   function automatic mat_t to_mat(input logic [127:0] hx);
      mat_t m;
      for (int i = 0; i < 16; i++) m[i % 4][i / 4] = hx[127-8*i -: 8];
      return m;
   endfunction

   function automatic rk_arr_t expand(input mat_t k);
      logic [31:0] w [44];
      logic [31:0] t;
      rk_arr_t     rk;
      for (int i = 0; i < 4; i++) w[i] = {k[0][i], k[1][i], k[2][i], k[3][i]};
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {SB[t[31:24]], SB[t[23:16]], SB[t[15:8]], SB[t[7:0]]} ^ {RCON[i/4-1], 24'h0};
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++)
         for (int c = 0; c < 4; c++)
            for (int b = 0; b < 4; b++) rk[r][b][c] = w[4*r+c][31-8*b -: 8];
      return rk;
   endfunction

   function automatic mat_t rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: issue rounds from a precomputed schedule
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_key <= '0; m_idx <= 0; m_vld <= 0; m_done <= 0;
         m_active <= 0; m_pend <= 0; m_wait <= 0;
      end else if (!en) begin
         m_idx <= 0; m_vld <= 0; m_done <= 0;
         m_active <= 0; m_pend <= 0; m_wait <= 0;
      end else if (load) begin
         m_rk <= expand(key); m_key <= key; m_idx <= 0; m_vld <= 0; m_done <= 0;
         m_active <= 1; m_pend <= 0; m_wait <= 0;
      end else if (m_pend) begin
         m_pend <= 0; m_idx <= m_idx + 1; m_key <= m_rk[m_idx+1]; m_vld <= 1; m_wait <= 1;
      end else if (m_wait) begin
         m_wait <= 0; m_vld <= 0;
         if (m_idx == 10) m_done <= 1;
      end else if (m_active && !m_done && req) begin
         m_pend <= 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("vld",  128'(key_vld_o),   128'(m_vld));
         check("done", 128'(key_done_o),  128'(m_done));
         check("idx",  128'(round_idx_o), 128'(m_idx));
         check("key",  round_key_o,       m_key);
      end
   end

   task automatic do_load(input mat_t k);
      @(negedge clk); key = k; load = 1;
      @(negedge clk); load = 0;
   endtask

   // call right after the request cycle; leaves us on the negedge showing the pulse
   task automatic wait_vld(input string nm);
      int n = 0;
      while (!key_vld_o && n < 6) begin @(negedge clk); n++; end
      check(nm, 128'(key_vld_o), 128'(1));
   endtask

   task automatic one_round(input string nm);
      req = 1; @(negedge clk); req = 0;
      wait_vld(nm);
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      mat_t    fips, k1, k2;
      rk_arr_t rk;
      int      cnt, last;
      clk = 0; rst_n = 0; en = 1; load = 0; req = 0; key = '0;
      for (int i = 0; i < 256; i++) SB[i] = sbox_calc(8'(i));

      fips = to_mat(128'h2b7e151628aed2a6abf7158809cf4f3c);
      rk = expand(fips);
      check("pin_sbox00", 128'(SB[0]), 128'(8'h63));
      check("pin_sbox53", 128'(SB[8'h53]), 128'(8'hed));
      check("pin_rk1", rk[1], to_mat(128'ha0fafe1788542cb123a339392a6c7605));
      check("pin_rk10", rk[10], to_mat(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

      repeat (2) @(negedge clk);
      chk_en = 1;
      check("rst_key", round_key_o, '0);
      check("rst_idx", 128'(round_idx_o), 128'(0));
      @(negedge clk); rst_n = 1;
      @(negedge clk);

      // asynchronous reset while a round is being computed
      do_load(rand_key());
      req = 1;
      @(posedge clk); #2; rst_n = 0; req = 0; #1;
      check("t1_async_key", round_key_o, '0);
      check("t1_async_idx", 128'(round_idx_o), 128'(0));
      check("t1_async_vld", 128'(key_vld_o), 128'(0));
      @(negedge clk); @(negedge clk); rst_n = 1;
      @(negedge clk);
      check("t1_no_partial", 128'(key_vld_o), 128'(0));

      // FIPS-197 A.1, round 1 with exact latency
      do_load(fips);
      req = 1; @(negedge clk); req = 0;
      check("t2_lat0", 128'(key_vld_o), 128'(0));
      @(negedge clk);
      check("t2_vld", 128'(key_vld_o), 128'(1));
      check("t2_idx", 128'(round_idx_o), 128'(1));
      check("t2_key", round_key_o, to_mat(128'ha0fafe1788542cb123a339392a6c7605));
      @(negedge clk);

      // rounds 2..10, then done and an ignored 11th request
      for (int r = 2; r <= 10; r++) begin
         req = 1; @(negedge clk); req = 0;
         wait_vld("t3_vld");
         check("t3_idx", 128'(round_idx_o), 128'(r));
         @(negedge clk);
      end
      check("t3_key10", round_key_o, to_mat(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
      check("t3_done", 128'(key_done_o), 128'(1));
      cnt = 0;
      req = 1;
      repeat (6) begin @(negedge clk); if (key_vld_o) cnt++; end
      req = 0;
      check("t3_req11", 128'(cnt), 128'(0));

      // request held high: one key every 3 cycles, exactly ten
      do_load(rand_key());
      req = 1; cnt = 0; last = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (key_vld_o) begin
            if (last >= 0) check("t4_spacing", 128'(i - last), 128'(3));
            last = i; cnt++;
         end
      end
      req = 0;
      check("t4_pulses", 128'(cnt), 128'(10));

      // load + request during CALC: abort, restart at round 1 of new key
      k1 = rand_key(); k2 = rand_key();
      do_load(k1);
      one_round("t5_r1");
      one_round("t5_r2");
      req = 1; @(negedge clk);
      load = 1; key = k2;
      @(negedge clk); load = 0; req = 0;
      check("t5_abort_vld", 128'(key_vld_o), 128'(0));
      check("t5_abort_key", round_key_o, k2);
      check("t5_abort_idx", 128'(round_idx_o), 128'(0));
      @(negedge clk);
      req = 1; @(negedge clk); req = 0;
      wait_vld("t5_new_vld");
      rk = expand(k2);
      check("t5_new_key", round_key_o, rk[1]);
      check("t5_new_idx", 128'(round_idx_o), 128'(1));
      @(negedge clk);

      // disable after round 4
      k1 = rand_key();
      do_load(k1);
      for (int r = 0; r < 4; r++) one_round("t6_round");
      en = 0; @(negedge clk); @(negedge clk);
      rk = expand(k1);
      check("t6_idx", 128'(round_idx_o), 128'(0));
      check("t6_done", 128'(key_done_o), 128'(0));
      check("t6_key_kept", round_key_o, rk[4]);
      en = 1; req = 1; cnt = 0;
      repeat (8) begin @(negedge clk); if (key_vld_o) cnt++; end
      req = 0;
      check("t6_ignored", 128'(cnt), 128'(0));
      k1 = rand_key();
      do_load(k1);
      one_round("t6_reload");
      rk = expand(k1);
      check("t6_reload_key", round_key_o, rk[1]);

      // randomized traffic, checked every cycle by the model
      do_load(rand_key());
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         en   = ($urandom_range(0, 79) != 0);
         load = ($urandom_range(0, 39) == 0);
         req  = ($urandom_range(0, 3) != 0);
         if (load) key = rand_key();
      end
      @(negedge clk); load = 0; req = 0; en = 1;
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
